// File: rtl/pool_pkg.sv
// Shared widths and FSM encoding for the pooling-tile scheduler.
package pool_pkg;

  localparam int unsigned TILE_DIM = 8;
  localparam int unsigned POOL_DIM = 4;
  localparam int unsigned TILE_W   = TILE_DIM * TILE_DIM;
  localparam int unsigned POOL_W   = POOL_DIM * POOL_DIM;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } pool_sched_state_t;

endpackage

// File: rtl/pool_tile_sched_if.sv
// Tile-request, engine and result signals of the pooling scheduler.
interface pool_tile_sched_if
  import pool_pkg::*;
#(
  parameter int unsigned NCH = 4
);
  localparam int unsigned CW = $clog2(NCH);

  logic [NCH-1:0]        i_tile_valid;
  logic [NCH-1:0]        o_tile_ready;
  logic [NCH*TILE_W-1:0] i_tile_data;
  logic [TILE_W-1:0]     o_pool_in;
  logic [POOL_W-1:0]     i_pool_out;
  logic                  o_res_valid;
  logic                  i_res_ready;
  logic [POOL_W-1:0]     o_res_data;
  logic [CW-1:0]         o_res_chan;
  logic                  o_busy;
  logic [15:0]           o_tile_cnt;

  modport master (
    input  i_tile_valid, i_tile_data, i_pool_out, i_res_ready,
    output o_tile_ready, o_pool_in, o_res_valid, o_res_data, o_res_chan,
           o_busy, o_tile_cnt
  );

  modport slave (
    output i_tile_valid, i_tile_data, i_pool_out, i_res_ready,
    input  o_tile_ready, o_pool_in, o_res_valid, o_res_data, o_res_chan,
           o_busy, o_tile_cnt
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  int unsigned idx;

  // Search wraps modulo N, not 2^W, so unused codes are never visited.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!any && req[idx[W-1:0]]) begin
        any              = 1'b1;
        gnt_idx          = idx[W-1:0];
        gnt[idx[W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pool_tile_sched.sv
// Round-robin scheduler feeding one shared 2x2 OR-pooling engine from NCH channels.
module pool_tile_sched
  import pool_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input logic                clk,
  input logic                rst,
  pool_tile_sched_if.master  bus
);

  localparam int unsigned CW = $clog2(NCH);

  pool_sched_state_t state_q, state_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     res_chan_q, res_chan_d;
  logic [TILE_W-1:0] pool_in_q, pool_in_d;
  logic [POOL_W-1:0] res_data_q, res_data_d;
  logic [15:0]       tile_cnt_q, tile_cnt_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q, busy_d;

  logic [NCH-1:0]    gnt;
  logic [CW-1:0]     gnt_idx;
  logic              any;
  logic [TILE_W-1:0] tile_sel;

  rr_arbiter #(.N(NCH), .W(CW)) u_arb (
    .req     (bus.i_tile_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    tile_sel = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (gnt_idx == CW'(c)) tile_sel = bus.i_tile_data[c*TILE_W +: TILE_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    res_chan_d = res_chan_q;
    pool_in_d  = pool_in_q;
    res_data_d = res_data_q;
    tile_cnt_d = tile_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          pool_in_d  = tile_sel;
          res_chan_d = gnt_idx;
          ptr_d      = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
          state_d    = ISSUE;
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        res_data_d = bus.i_pool_out;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.i_res_ready) begin
          tile_cnt_d = tile_cnt_q + 16'd1;
          state_d    = IDLE;
        end
      end
    endcase
    busy_d      = (state_d != IDLE);
    res_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      res_chan_q  <= '0;
      pool_in_q   <= '0;
      res_data_q  <= '0;
      tile_cnt_q  <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      res_chan_q  <= res_chan_d;
      pool_in_q   <= pool_in_d;
      res_data_q  <= res_data_d;
      tile_cnt_q  <= tile_cnt_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.o_tile_ready = (state_q == IDLE) ? gnt : '0;
  assign bus.o_pool_in    = pool_in_q;
  assign bus.o_res_valid  = res_valid_q;
  assign bus.o_res_data   = res_data_q;
  assign bus.o_res_chan   = res_chan_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_tile_cnt   = tile_cnt_q;

endmodule
